// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: command sequencer between the UART RX byte stream, the
// register file, the ALU and the TX FIFO (REF_CLK domain).
//
// Opcodes: 0xAA RF write (addr, data), 0xBB RF read (addr),
//          0xCC ALU with operands (A, B, func), 0xDD ALU on RF[0]/RF[1] (func).
//
// Ports
//   CLK, RST               clock; synchronous active-low reset
//   RX_P_DATA, RX_D_VLD    received byte and its one-cycle valid
//   RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN   register file request
//   RF_RD_DATA, RF_RD_VLD  register file read response
//   ALU_FUNC, ALU_EN, CLK_GATE_EN             ALU request / clock gate
//   ALU_OUT, ALU_OUT_VLD   ALU result
//   TX_P_DATA, TX_D_VLD    byte write into the TX FIFO
//   FIFO_FULL              TX FIFO back-pressure
//   CMD_ERR                one-cycle pulse on bad opcode (or inter-byte timeout)
//
// Optional feature macro: SYS_CMD_TIMEOUT_EN enables the inter-byte timeout.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for an opcode byte
// WR_ADDR   | 0xAA: waiting for address byte
// WR_DATA   | 0xAA: waiting for data byte
// RD_ADDR   | 0xBB: waiting for address byte
// RD_WAIT   | RF read strobe issued, waiting for RF_RD_VLD
// OP_A      | 0xCC: waiting for operand A
// OP_B      | 0xCC: waiting for operand B
// FUNC      | waiting for ALU function byte
// RF_OPA    | RF[0] <= A write strobe active
// RF_OPB    | RF[1] <= B write strobe active
// ALU_START | ALU_EN strobe active
// ALU_WAIT  | waiting for ALU_OUT_VLD
// TX_B0     | sending low (or only) response byte
// TX_B1     | sending high response byte
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUNC_WIDTH = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     RF_ADDR,
    output logic                      RF_WR_EN,
    output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
    output logic                      RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
    input  logic                      RF_RD_VLD,
    output logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC,
    output logic                      ALU_EN,
    output logic                      CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      FIFO_FULL,
    output logic                      CMD_ERR
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUNC,
        RF_OPA, RF_OPB, ALU_START, ALU_WAIT, TX_B0, TX_B1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPC_ALN = DATA_WIDTH'(8'hDD);

    state_t                    state, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [2*DATA_WIDTH-1:0]   result_q, result_d;
    logic                      with_ops_q, with_ops_d;
    logic                      two_byte_q, two_byte_d;

    logic [ADDR_WIDTH-1:0]     rf_addr_d;
    logic                      rf_wr_en_d, rf_rd_en_d, alu_en_d, tx_d_vld_d, cmd_err_d;
    logic                      clk_gate_en_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_d, tx_p_data_d;
    logic [ALU_FUNC_WIDTH-1:0] alu_func_d;

`ifdef SYS_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    logic             wait_st;
`else
    // Keeps the parameter referenced in builds without the timer.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d       = state;
        addr_d        = addr_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        result_d      = result_q;
        with_ops_d    = with_ops_q;
        two_byte_d    = two_byte_q;
        rf_addr_d     = RF_ADDR;
        rf_wr_data_d  = RF_WR_DATA;
        alu_func_d    = ALU_FUNC;
        tx_p_data_d   = TX_P_DATA;
        rf_wr_en_d    = 1'b0;
        rf_rd_en_d    = 1'b0;
        alu_en_d      = 1'b0;
        tx_d_vld_d    = 1'b0;
        cmd_err_d     = 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
        wait_st       = 1'b0;
        tmo_cnt_d     = '0;
`endif

        case (state)
            IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    OPC_WR:  state_d = WR_ADDR;
                    OPC_RD:  state_d = RD_ADDR;
                    OPC_ALU: begin state_d = OP_A; with_ops_d = 1'b1; end
                    OPC_ALN: begin state_d = FUNC; with_ops_d = 1'b0; end
                    default: cmd_err_d = 1'b1;
                endcase
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                rf_addr_d    = addr_q;
                rf_wr_data_d = RX_P_DATA;
                rf_wr_en_d   = 1'b1;
                state_d      = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                rf_rd_en_d = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: if (RF_RD_VLD) begin
                result_d    = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                tx_p_data_d = RF_RD_DATA;
                two_byte_d  = 1'b0;
                state_d     = TX_B0;
            end
            OP_A: if (RX_D_VLD) begin
                opa_d   = RX_P_DATA;
                state_d = OP_B;
            end
            OP_B: if (RX_D_VLD) begin
                opb_d   = RX_P_DATA;
                state_d = FUNC;
            end
            FUNC: if (RX_D_VLD) begin
                alu_func_d = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
                if (with_ops_q) begin
                    // Operands reach the RF only once the frame is complete.
                    rf_addr_d    = '0;
                    rf_wr_data_d = opa_q;
                    rf_wr_en_d   = 1'b1;
                    state_d      = RF_OPA;
                end else begin
                    alu_en_d = 1'b1;
                    state_d  = ALU_START;
                end
            end
            RF_OPA: begin
                rf_addr_d    = ADDR_WIDTH'(1);
                rf_wr_data_d = opb_q;
                rf_wr_en_d   = 1'b1;
                state_d      = RF_OPB;
            end
            RF_OPB: begin
                alu_en_d = 1'b1;
                state_d  = ALU_START;
            end
            ALU_START: state_d = ALU_WAIT;
            ALU_WAIT: if (ALU_OUT_VLD) begin
                result_d    = ALU_OUT;
                tx_p_data_d = ALU_OUT[DATA_WIDTH-1:0];
                two_byte_d  = 1'b1;
                state_d     = TX_B0;
            end
            // The FIFO write pulse follows the cycle in which FIFO_FULL was low.
            TX_B0: if (!FIFO_FULL) begin
                tx_p_data_d = result_q[DATA_WIDTH-1:0];
                tx_d_vld_d  = 1'b1;
                state_d     = two_byte_q ? TX_B1 : IDLE;
            end
            TX_B1: if (!FIFO_FULL) begin
                tx_p_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                tx_d_vld_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SYS_CMD_TIMEOUT_EN
        wait_st = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                  (state == OP_A) || (state == OP_B) || (state == FUNC);
        if (wait_st && !RX_D_VLD && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES))) begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
        end
        tmo_cnt_d = (!wait_st || RX_D_VLD || (state_d != state)) ? '0 : tmo_cnt + TMO_W'(1);
`endif

        clk_gate_en_d = (state_d == RF_OPA) || (state_d == RF_OPB) ||
                        (state_d == ALU_START) || (state_d == ALU_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            with_ops_q  <= 1'b0;
            two_byte_q  <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            RF_RD_EN    <= 1'b0;
            ALU_FUNC    <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
`ifdef SYS_CMD_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            with_ops_q  <= with_ops_d;
            two_byte_q  <= two_byte_d;
            RF_ADDR     <= rf_addr_d;
            RF_WR_EN    <= rf_wr_en_d;
            RF_WR_DATA  <= rf_wr_data_d;
            RF_RD_EN    <= rf_rd_en_d;
            ALU_FUNC    <= alu_func_d;
            ALU_EN      <= alu_en_d;
            CLK_GATE_EN <= clk_gate_en_d;
            TX_P_DATA   <= tx_p_data_d;
            TX_D_VLD    <= tx_d_vld_d;
            CMD_ERR     <= cmd_err_d;
`ifdef SYS_CMD_TIMEOUT_EN
            tmo_cnt     <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: directed command frames, RF and ALU
// responder models, and scoreboards for RF writes and TX bytes.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA = '0;
    logic        RF_RD_VLD = 1'b0;
    logic [3:0]  ALU_FUNC;
    logic        ALU_EN;
    logic        CLK_GATE_EN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL = 1'b0;
    logic        CMD_ERR;

    localparam int TMO = 4096;

    sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [11:0] exp_wr[$];
    logic [7:0]  rf_m[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0:    return {8'h00, a} - {8'h00, b};
            4'd1:    return {8'h00, a} + {8'h00, b};
            4'd2:    return a * b;
            default: return {a, b};
        endcase
    endfunction

    // Output monitor: scoreboard pops and strobe counting, away from the active edge.
    always @(negedge CLK) begin
        if (RF_WR_EN === 1'b1) begin
            wr_cnt++;
            rf_m[RF_ADDR] = RF_WR_DATA;
            chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) chk("wr_addr_data", {20'h0, RF_ADDR, RF_WR_DATA}, {20'h0, exp_wr.pop_front()});
        end
        if (TX_D_VLD === 1'b1) begin
            tx_cnt++;
            chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) chk("tx_byte", {24'h0, TX_P_DATA}, {24'h0, exp_tx.pop_front()});
        end
        if (RF_RD_EN === 1'b1) rd_cnt++;
        if (ALU_EN === 1'b1)   alu_cnt++;
        if (CMD_ERR === 1'b1)  err_cnt++;
        if (ALU_OUT_VLD === 1'b1) chk("gate_on_capture", {31'h0, CLK_GATE_EN}, 32'd1);
    end

    // RF read responder: data two cycles after the strobe.
    initial begin
        logic [3:0] a;
        forever begin
            @(negedge CLK);
            if (RF_RD_EN === 1'b1) begin
                a = RF_ADDR;
                repeat (2) @(posedge CLK);
                #1 RF_RD_DATA = rf_m[a];
                RF_RD_VLD = 1'b1;
                @(posedge CLK);
                #1 RF_RD_VLD = 1'b0;
            end
        end
    end

    // ALU responder: result three cycles after ALU_EN.
    initial begin
        logic [3:0] f;
        forever begin
            @(negedge CLK);
            if (ALU_EN === 1'b1) begin
                f = ALU_FUNC;
                repeat (3) @(posedge CLK);
                #1 ALU_OUT = alu_calc(f, rf_m[0], rf_m[1]);
                ALU_OUT_VLD = 1'b1;
                @(negedge CLK);
                chk("alu_func_hold", {28'h0, ALU_FUNC}, {28'h0, f});
                @(posedge CLK);
                #1 ALU_OUT_VLD = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1 RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        @(posedge CLK);
        #1 RX_D_VLD = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    initial begin
        int w0, r0, a0, e0, t0, n;
        for (int i = 0; i < 16; i++) rf_m[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        chk("rst_strobes", {26'h0, RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CMD_ERR, CLK_GATE_EN}, 32'h0);
        chk("rst_regs", {8'h0, RF_ADDR, RF_WR_DATA, ALU_FUNC, TX_P_DATA}, 32'h0);

        // AA,05,77: single write, no response
        w0 = wr_cnt; t0 = tx_cnt;
        exp_wr.push_back({4'h5, 8'h77});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h77);
        chk("wr_latency", {31'h0, RF_WR_EN}, 32'd1);
        settle(10);
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_no_tx", tx_cnt - t0, 0);

        // BB,05: one read strobe, one TX byte
        r0 = rd_cnt; t0 = tx_cnt;
        exp_tx.push_back(8'h77);
        send_byte(8'hBB); send_byte(8'h05);
        chk("rd_latency", {27'h0, RF_RD_EN, RF_ADDR}, {27'h0, 1'b1, 4'h5});
        settle(12);
        chk("rd_count", rd_cnt - r0, 1);
        chk("rd_tx_count", tx_cnt - t0, 1);

        // CC,30,40,02: multiply, checks byte order (0x0C00 -> 00 then 0C)
        t0 = tx_cnt;
        exp_wr.push_back({4'h0, 8'h30}); exp_wr.push_back({4'h1, 8'h40});
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h0C);
        send_byte(8'hCC); send_byte(8'h30); send_byte(8'h40); send_byte(8'h02);
        settle(15);
        chk("cc_mul_tx_count", tx_cnt - t0, 2);

        // CC,05,03,01: add, ALU_EN three cycles after func byte
        a0 = alu_cnt; t0 = tx_cnt;
        exp_wr.push_back({4'h0, 8'h05}); exp_wr.push_back({4'h1, 8'h03});
        exp_tx.push_back(8'h08); exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h01);
        chk("cc_opa_wr", {27'h0, RF_WR_EN, RF_ADDR}, {27'h0, 1'b1, 4'h0});
        chk("cc_gate_on", {31'h0, CLK_GATE_EN}, 32'd1);
        settle(1);
        chk("cc_opb_wr", {27'h0, RF_WR_EN, RF_ADDR}, {27'h0, 1'b1, 4'h1});
        chk("cc_no_alu_yet", {31'h0, ALU_EN}, 32'd0);
        settle(1);
        chk("cc_alu_en", {27'h0, ALU_EN, ALU_FUNC}, {27'h0, 1'b1, 4'h1});
        settle(15);
        chk("cc_alu_count", alu_cnt - a0, 1);
        chk("cc_tx_count", tx_cnt - t0, 2);
        chk("cc_gate_off", {31'h0, CLK_GATE_EN}, 32'd0);

        // DD,02 with FIFO full: 5*3 = 0x000F -> 0F then 00, only after release
        t0 = tx_cnt; w0 = wr_cnt;
        FIFO_FULL = 1'b1;
        exp_tx.push_back(8'h0F); exp_tx.push_back(8'h00);
        send_byte(8'hDD); send_byte(8'h02);
        chk("dd_alu_latency", {27'h0, ALU_EN, ALU_FUNC}, {27'h0, 1'b1, 4'h2});
        n = 0;
        while (ALU_OUT_VLD !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        chk("dd_alu_vld_seen", {31'h0, ALU_OUT_VLD}, 32'd1);
        settle(10);
        chk("dd_no_tx_while_full", tx_cnt - t0, 0);
        FIFO_FULL = 1'b0;
        settle(10);
        chk("dd_tx_count", tx_cnt - t0, 2);
        chk("dd_no_rf_write", wr_cnt - w0, 0);

        // 0x55 in IDLE: one-cycle CMD_ERR, then a normal write
        e0 = err_cnt; w0 = wr_cnt;
        send_byte(8'h55);
        chk("err_pulse", {31'h0, CMD_ERR}, 32'd1);
        settle(1);
        chk("err_one_cycle", {31'h0, CMD_ERR}, 32'd0);
        exp_wr.push_back({4'h3, 8'h11});
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        settle(5);
        chk("err_count", err_cnt - e0, 1);
        chk("after_err_wr", wr_cnt - w0, 1);

        // Reset between AA and 05: frame discarded, 05 and 77 become bad opcodes
        w0 = wr_cnt; e0 = err_cnt;
        send_byte(8'hAA);
        do_reset();
        chk("midrst_regs", {12'h0, RF_ADDR, ALU_FUNC, TX_P_DATA, CLK_GATE_EN, 3'b0}, 32'h0);
        send_byte(8'h05); send_byte(8'h77);
        settle(5);
        chk("midrst_no_wr", wr_cnt - w0, 0);
        chk("midrst_errs", err_cnt - e0, 2);

        // Byte arriving in RD_WAIT is dropped silently
        exp_wr.push_back({4'h6, 8'h5A});
        send_byte(8'hAA); send_byte(8'h06); send_byte(8'h5A);
        e0 = err_cnt; t0 = tx_cnt;
        exp_tx.push_back(8'h5A);
        send_byte(8'hBB); send_byte(8'h06);
        send_byte(8'hAA);
        settle(12);
        chk("drop_tx_count", tx_cnt - t0, 1);
        chk("drop_no_err", err_cnt - e0, 0);
        w0 = wr_cnt;
        exp_wr.push_back({4'h7, 8'h12});
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h12);
        settle(5);
        chk("drop_then_wr", wr_cnt - w0, 1);

`ifdef SYS_CMD_TIMEOUT_EN
        // CC,01 then silence: CMD_ERR after the timeout, no RF write
        w0 = wr_cnt; e0 = err_cnt;
        send_byte(8'hCC); send_byte(8'h01);
        settle(TMO - 20);
        chk("tmo_not_early", err_cnt - e0, 0);
        settle(40);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_no_wr", wr_cnt - w0, 0);
`endif

        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("wr_queue_drained", exp_wr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
